// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared constants and helpers for the multi-channel clock generator
package clkgen_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int DIV_DISABLED = 0;
  localparam int CH_IDX_W = 3;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with shadowed divisor applied at period boundaries
module clk_div_channel
  import clkgen_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         refclk,
  input  logic         rst,
  input  logic [W-1:0] def_div_i,
  input  logic         wr_i,
  input  logic [W-1:0] wr_div_i,
  output logic         pending_o,
  output logic         ce_o,
  output logic         clk_o,
  output logic         div_nz_o
);
  logic [W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic pend_q, pend_d, ce_q, ce_d, clk_q, clk_d, off, wrap, apply;
  // next state: a disabled channel treats every edge as a boundary so updates land immediately
  always_comb begin
    off = div_q == W'(DIV_DISABLED);
    wrap = off || cnt_q == div_q - W'(1);
    apply = pend_q && wrap;
    div_d = apply ? shadow_q : div_q;
    cnt_d = wrap ? '0 : cnt_q + W'(1);
    ce_d = div_d != W'(DIV_DISABLED) && cnt_d == div_d - W'(1);
    clk_d = cnt_d < (div_d >> 1);
    pend_d = !apply && (pend_q || wr_i);
    shadow_d = wr_i ? wr_div_i : shadow_q;
  end
  // state registers; outputs decode the post-edge count so they carry no extra latency
  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= def_div_i;
      shadow_q <= '0;
      pend_q <= 1'b0;
      ce_q <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      ce_q <= ce_d;
      clk_q <= clk_d;
    end
  end
  assign pending_o = pend_q;
  assign ce_o = ce_q;
  assign clk_o = clk_q;
  assign div_nz_o = !off;
endmodule

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: multi-channel clock-enable/divided-clock generator with lock indication
module clk_gen_multi
  import clkgen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LOCK_CYCLES = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIVS = {8'd1, 8'd2}
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_ready,
  output logic [NUM_CH-1:0]   ce_o,
  output logic [NUM_CH-1:0]   clk_o,
  output logic [NUM_CH-1:0]   ch_locked,
  output logic                locked
);
  localparam int LK_W = clog2(LOCK_CYCLES + 1);
  logic [NUM_CH-1:0] pend, nz, wr, chl_q, chl_d;
  logic [LK_W-1:0] lk_q, lk_d;
  logic glock, locked_q, locked_d;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(.W(CNT_W)) u_ch (
      .refclk(refclk),
      .rst(rst),
      .def_div_i(DEFAULT_DIVS[i*CNT_W +: CNT_W]),
      .wr_i(wr[i]),
      .wr_div_i(cfg_div),
      .pending_o(pend[i]),
      .ce_o(ce_o[i]),
      .clk_o(clk_o[i]),
      .div_nz_o(nz[i])
    );
  end
  // channel decode: out-of-range targets are always ready and their writes go nowhere
  always_comb begin
    cfg_ready = 1'b1;
    wr = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (cfg_ch == CH_IDX_W'(k)) begin
        cfg_ready = !pend[k];
        wr[k] = cfg_wr && !pend[k];
      end
    glock = lk_q == LK_W'(LOCK_CYCLES);
    lk_d = glock ? lk_q : lk_q + LK_W'(1);
    chl_d = {NUM_CH{glock}} & ~pend & nz;
    locked_d = glock && !(|pend);
  end
  // lock counter saturates; lock flags are registered from current pending state
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_q <= '0;
      chl_q <= '0;
      locked_q <= 1'b0;
    end else begin
      lk_q <= lk_d;
      chl_q <= chl_d;
      locked_q <= locked_d;
    end
  end
  assign ch_locked = chl_q;
  assign locked = locked_q;
endmodule
